// File: rtl/layer_mac_scheduler_if.sv
// ---------------------------------------------------------------------------
// layer_mac_scheduler_if
// Groups the control handshake, operand buses and the shared-MAC connection
// of layer_mac_scheduler.
//   START/ABORT        run request / cancel (driven by the host)
//   BUSY/DONE          run status, DONE is a one-cycle completion pulse
//   WEIGHTS_IN/BIAS_IN/VALUES_IN  live operand buses, stable while BUSY
//   MAC_A/MAC_B/MAC_EN/MAC_CLR    operand strobe toward the external MAC
//   MAC_ACC            accumulator value returned by the external MAC
//   VALUES_OUT         registered per-neuron results
// Modports: slave = the scheduler, master = the host/MAC side.
// ---------------------------------------------------------------------------
interface layer_mac_scheduler_if #(
  parameter int NUM_NEURONS = 6,
  parameter int NUM_INPUTS  = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 20
);
  logic                                       START;
  logic                                       ABORT;
  logic                                       BUSY;
  logic                                       DONE;
  logic [NUM_NEURONS*NUM_INPUTS*DATA_WIDTH-1:0] WEIGHTS_IN;
  logic [NUM_NEURONS*DATA_WIDTH-1:0]          BIAS_IN;
  logic [NUM_INPUTS*DATA_WIDTH-1:0]           VALUES_IN;
  logic [DATA_WIDTH-1:0]                      MAC_A;
  logic [DATA_WIDTH-1:0]                      MAC_B;
  logic                                       MAC_EN;
  logic                                       MAC_CLR;
  logic [ACC_WIDTH-1:0]                       MAC_ACC;
  logic [NUM_NEURONS*DATA_WIDTH-1:0]          VALUES_OUT;

  modport slave (
    input  START, ABORT, WEIGHTS_IN, BIAS_IN, VALUES_IN, MAC_ACC,
    output BUSY, DONE, MAC_A, MAC_B, MAC_EN, MAC_CLR, VALUES_OUT
  );

  modport master (
    output START, ABORT, WEIGHTS_IN, BIAS_IN, VALUES_IN, MAC_ACC,
    input  BUSY, DONE, MAC_A, MAC_B, MAC_EN, MAC_CLR, VALUES_OUT
  );
endinterface

// File: rtl/layer_mac_scheduler.sv
// ---------------------------------------------------------------------------
// layer_mac_scheduler
// Runs one fully-connected layer through a single time-shared external MAC.
// For each neuron: NUM_INPUTS weight*value products (first one clears the
// accumulator), one bias*1.0 product, MAC_LATENCY drain cycles, then the
// accumulator is rescaled, saturated (optionally ReLU-clamped) and stored.
// Ports:
//   CLK   clock
//   RSTN  synchronous active-low reset
//   bus   layer_mac_scheduler_if.slave (control, operands, MAC link, results)
// ---------------------------------------------------------------------------
module layer_mac_scheduler #(
  parameter int NUM_NEURONS = 6,
  parameter int NUM_INPUTS  = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int FRAC_BITS   = 5,
  parameter int MAC_LATENCY = 2,
  parameter int ACC_WIDTH   = 20,
  parameter int RELU        = 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  layer_mac_scheduler_if.slave  bus
);

  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int IW = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
  localparam int LW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

  localparam logic [NW-1:0] LAST_N = NW'(NUM_NEURONS - 1);
  localparam logic [IW-1:0] LAST_I = IW'(NUM_INPUTS - 1);
  localparam logic [LW-1:0] LAST_D = LW'(MAC_LATENCY - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(1 << (DATA_WIDTH - 1)));
  // 1.0 in the operand format: multiplying the bias by it aligns it with the
  // Q(2*FRAC_BITS) products already in the accumulator.
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1 << FRAC_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BIAS,
    ST_DRAIN,
    ST_CAPTURE
  } state_t;

  state_t                          state_q, state_d;
  logic [NW-1:0]                   n_q, n_d;
  logic [IW-1:0]                   i_q, i_d;
  logic [LW-1:0]                   lat_q, lat_d;
  logic                            done_q, done_d;
  logic [DATA_WIDTH-1:0]           mac_a_q, mac_a_d;
  logic [DATA_WIDTH-1:0]           mac_b_q, mac_b_d;
  logic                            mac_en_q, mac_en_d;
  logic                            mac_clr_q, mac_clr_d;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] vals_q, vals_d;

  logic signed [ACC_WIDTH-1:0]     acc_shift;
  logic [DATA_WIDTH-1:0]           result;

  // Rescale Q(2F) -> Q(F) with floor rounding, saturate, then ReLU.
  always_comb begin
    acc_shift = $signed(bus.MAC_ACC) >>> FRAC_BITS;
    if (acc_shift > SAT_MAX) begin
      result = SAT_MAX[DATA_WIDTH-1:0];
    end else if (acc_shift < SAT_MIN) begin
      result = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      result = acc_shift[DATA_WIDTH-1:0];
    end
    if ((RELU != 0) && acc_shift[ACC_WIDTH-1]) begin
      result = '0;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    lat_d   = lat_q;
    done_d  = 1'b0;
    vals_d  = vals_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d = ST_ISSUE;
          n_d     = '0;
          i_d     = '0;
        end
      end
      ST_ISSUE: begin
        if (i_q == LAST_I) begin
          state_d = ST_BIAS;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      ST_BIAS: begin
        state_d = ST_DRAIN;
        lat_d   = '0;
      end
      ST_DRAIN: begin
        if (lat_q == LAST_D) begin
          state_d = ST_CAPTURE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        vals_d[int'(n_q)*DATA_WIDTH +: DATA_WIDTH] = result;
        if (n_q == LAST_N) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_ISSUE;
          n_d     = n_q + 1'b1;
          i_d     = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // ABORT overrides everything, including a START in IDLE and a pending write.
    if (bus.ABORT) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      vals_d  = vals_q;
    end

    // MAC strobes are registered, so they are derived from the state being
    // entered: the operands appear in the same cycle the FSM is in ISSUE/BIAS.
    mac_a_d   = '0;
    mac_b_d   = '0;
    mac_en_d  = 1'b0;
    mac_clr_d = 1'b0;
    case (state_d)
      ST_ISSUE: begin
        mac_a_d   = bus.WEIGHTS_IN[(int'(n_d)*NUM_INPUTS + int'(i_d))*DATA_WIDTH +: DATA_WIDTH];
        mac_b_d   = bus.VALUES_IN[int'(i_d)*DATA_WIDTH +: DATA_WIDTH];
        mac_en_d  = 1'b1;
        mac_clr_d = (i_d == '0);
      end
      ST_BIAS: begin
        mac_a_d  = bus.BIAS_IN[int'(n_d)*DATA_WIDTH +: DATA_WIDTH];
        mac_b_d  = ONE;
        mac_en_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!RSTN) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      i_q       <= '0;
      lat_q     <= '0;
      done_q    <= 1'b0;
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
      // NOTE: the result bank is visible at the ports and must read 0 after
      // reset, so unlike a plain storage array it is explicitly reset.
      vals_q    <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      i_q       <= i_d;
      lat_q     <= lat_d;
      done_q    <= done_d;
      mac_a_q   <= mac_a_d;
      mac_b_q   <= mac_b_d;
      mac_en_q  <= mac_en_d;
      mac_clr_q <= mac_clr_d;
      vals_q    <= vals_d;
    end
  end

  assign bus.BUSY       = (state_q != ST_IDLE);
  assign bus.DONE       = done_q;
  assign bus.MAC_A      = mac_a_q;
  assign bus.MAC_B      = mac_b_q;
  assign bus.MAC_EN     = mac_en_q;
  assign bus.MAC_CLR    = mac_clr_q;
  assign bus.VALUES_OUT = vals_q;

endmodule

// File: tb/tb_layer_mac_scheduler.sv
// ---------------------------------------------------------------------------
// tb_layer_mac_scheduler
// Two schedulers (RELU=1 and RELU=0) share stimulus; each has its own
// behavioural MAC. Expected result banks are pushed to a scoreboard when a
// run starts and popped when DONE is seen. An operand-trace monitor checks
// MAC_A/MAC_B/MAC_EN/MAC_CLR/BUSY against the neuron schedule every cycle.
// ---------------------------------------------------------------------------
module tb_layer_mac_scheduler;
  localparam int NN  = 6;
  localparam int NI  = 9;
  localparam int DW  = 8;
  localparam int FB  = 5;
  localparam int LAT = 2;
  localparam int AW  = 20;
  localparam int PER = NI + 2 + LAT;
  localparam int RUN = NN * PER;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  layer_mac_scheduler_if #(.NUM_NEURONS(NN), .NUM_INPUTS(NI), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();
  layer_mac_scheduler_if #(.NUM_NEURONS(NN), .NUM_INPUTS(NI), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus_nr ();

  layer_mac_scheduler #(.NUM_NEURONS(NN), .NUM_INPUTS(NI), .DATA_WIDTH(DW), .FRAC_BITS(FB),
                        .MAC_LATENCY(LAT), .ACC_WIDTH(AW), .RELU(1))
    dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));
  layer_mac_scheduler #(.NUM_NEURONS(NN), .NUM_INPUTS(NI), .DATA_WIDTH(DW), .FRAC_BITS(FB),
                        .MAC_LATENCY(LAT), .ACC_WIDTH(AW), .RELU(0))
    dut_nr (.CLK(CLK), .RSTN(RSTN), .bus(bus_nr));

  assign bus_nr.START      = bus.START;
  assign bus_nr.ABORT      = bus.ABORT;
  assign bus_nr.WEIGHTS_IN = bus.WEIGHTS_IN;
  assign bus_nr.BIAS_IN    = bus.BIAS_IN;
  assign bus_nr.VALUES_IN  = bus.VALUES_IN;

  // Behavioural MAC: accumulator register plus one output stage (latency 2).
  function automatic logic signed [AW-1:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int pa, pb;
    pa = $signed(a);
    pb = $signed(b);
    return AW'(pa * pb);
  endfunction

  logic signed [AW-1:0] acc_r = '0, acc_p = '0, acc_nr_r = '0, acc_nr_p = '0;
  always @(posedge CLK) begin
    if (bus.MAC_EN)
      acc_r <= bus.MAC_CLR ? prod(bus.MAC_A, bus.MAC_B) : acc_r + prod(bus.MAC_A, bus.MAC_B);
    acc_p <= acc_r;
    if (bus_nr.MAC_EN)
      acc_nr_r <= bus_nr.MAC_CLR ? prod(bus_nr.MAC_A, bus_nr.MAC_B)
                                 : acc_nr_r + prod(bus_nr.MAC_A, bus_nr.MAC_B);
    acc_nr_p <= acc_nr_r;
  end
  assign bus.MAC_ACC    = acc_p;
  assign bus_nr.MAC_ACC = acc_nr_p;

  // Checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Stimulus data and reference model
  int w [NN][NI];
  int v [NI];
  int b [NN];

  task automatic set_pattern(input int p);
    for (int n = 0; n < NN; n++) begin
      b[n] = 0;
      for (int i = 0; i < NI; i++) w[n][i] = 32'h20;
    end
    for (int i = 0; i < NI; i++) v[i] = 32'h08;
    if (p == 2 || p == 3) begin
      for (int i = 0; i < NI; i++) begin
        v[i]    = 127;
        w[2][i] = (p == 2) ? 127 : -127;
      end
      b[2] = 127;
    end
    if (p == 4) begin
      for (int n = 0; n < NN; n++) begin
        b[n] = n * 8 - 20;
        for (int i = 0; i < NI; i++) w[n][i] = ((n * 7 + i * 3) % 64) - 32;
      end
      for (int i = 0; i < NI; i++) v[i] = ((i * 5) % 32) - 16;
    end
    for (int n = 0; n < NN; n++) begin
      bus.BIAS_IN[n*DW +: DW] = DW'(b[n]);
      for (int i = 0; i < NI; i++) bus.WEIGHTS_IN[(n*NI + i)*DW +: DW] = DW'(w[n][i]);
    end
    for (int i = 0; i < NI; i++) bus.VALUES_IN[i*DW +: DW] = DW'(v[i]);
  endtask

  function automatic logic [DW-1:0] model_neuron(input int n, input bit relu);
    int s, r;
    s = b[n] * (1 << FB);
    for (int i = 0; i < NI; i++) s += w[n][i] * v[i];
    r = s >>> FB;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    if (relu && r < 0) r = 0;
    return DW'(r);
  endfunction

  function automatic logic [NN*DW-1:0] model_bank(input bit relu);
    logic [NN*DW-1:0] bank;
    for (int n = 0; n < NN; n++) bank[n*DW +: DW] = model_neuron(n, relu);
    return bank;
  endfunction

  typedef struct packed {
    logic [NN*DW-1:0] r;
    logic [NN*DW-1:0] nr;
  } exp_t;

  exp_t sb[$];
  logic [NN*DW-1:0] sh_r = '0, sh_nr = '0;  // expected current VALUES_OUT contents

  int cyc       = 0;
  int cur_start = 0;
  bit run_active = 1'b0;
  int en_cnt = 0, clr_cnt = 0, trace_err = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int cur_rel();
    return cyc - cur_start + 1;
  endfunction

  // Operand trace + scoreboard pop
  always @(negedge CLK) begin
    int rel, n, p;
    logic [DW-1:0] ea, eb;
    logic ee, ec;
    exp_t e;
    rel = cur_rel();
    if (run_active && rel >= 1 && rel <= RUN) begin
      n  = (rel - 1) / PER;
      p  = (rel - 1) % PER;
      ee = (p <= NI);
      ec = (p == 0);
      ea = (p < NI) ? DW'(w[n][p]) : (p == NI) ? DW'(b[n]) : '0;
      eb = (p < NI) ? DW'(v[p])    : (p == NI) ? DW'(1 << FB) : '0;
      if (bus.MAC_EN !== ee || bus.MAC_CLR !== ec || bus.MAC_A !== ea ||
          bus.MAC_B !== eb || bus.BUSY !== 1'b1 || bus.DONE !== 1'b0)
        trace_err++;
      if (bus.MAC_EN === 1'b1) en_cnt++;
      if (bus.MAC_EN === 1'b1 && bus.MAC_CLR === 1'b1) clr_cnt++;
    end
    if (bus.DONE === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("done_cycle", 64'(rel), 64'(RUN + 1));
        check("done_nr", bus_nr.DONE, 1'b1);
        check("values_relu", bus.VALUES_OUT, e.r);
        check("values_norelu", bus_nr.VALUES_OUT, e.nr);
        check("mac_en_count", 64'(en_cnt), 64'(NN * (NI + 1)));
        check("mac_clr_count", 64'(clr_cnt), 64'(NN));
        check("trace_errors", 64'(trace_err), 64'd0);
        run_active = 1'b0;
      end
    end
  end

  // Called at a negedge; START is sampled by the next posedge (rel 0 -> 1).
  task automatic start_run(input bit expect_done);
    exp_t e;
    e.r  = model_bank(1'b1);
    e.nr = model_bank(1'b0);
    if (expect_done) begin
      sb.push_back(e);
      sh_r  = e.r;
      sh_nr = e.nr;
    end
    cur_start  = cyc + 1;
    en_cnt     = 0;
    clr_cnt    = 0;
    trace_err  = 0;
    run_active = 1'b1;
    bus.START  = 1'b1;
    @(negedge CLK);
    bus.START  = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    while (cur_rel() < r) @(negedge CLK);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge CLK);
      seen = bus.DONE;
    end
    check("done_seen", seen, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {bus.BUSY, bus.DONE, bus.MAC_EN, bus.MAC_CLR, bus.MAC_A, bus.MAC_B}, '0);
    check({tag, "_vals"}, bus.VALUES_OUT, '0);
    check({tag, "_ctl_nr"}, {bus_nr.BUSY, bus_nr.DONE, bus_nr.MAC_EN, bus_nr.MAC_CLR,
                             bus_nr.MAC_A, bus_nr.MAC_B}, '0);
    check({tag, "_vals_nr"}, bus_nr.VALUES_OUT, '0);
  endtask

  initial begin
    logic [NN*DW-1:0] exp_r, exp_nr;
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    set_pattern(1);
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RSTN = 1'b1;
    @(negedge CLK);

    // Run A: 1.0 * 0.25 * 9 inputs = 2.25 in every slot
    start_run(1'b1);
    check("busy_first_cycle", bus.BUSY, 1'b1);
    wait_done();
    check("all_slots_2p25", bus.VALUES_OUT, {NN{8'h48}});
    @(negedge CLK);
    check("busy_after_done", bus.BUSY, 1'b0);

    // Run B: neuron 2 positive saturation; stray START at cycle 5 is ignored
    set_pattern(2);
    start_run(1'b1);
    wait_rel(5);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    wait_done();
    check("sat_pos_slot2", bus.VALUES_OUT[2*DW +: DW], 8'h7F);
    repeat (10) @(negedge CLK);
    check("start_not_queued", bus.BUSY, 1'b0);

    // Run C: negated weights -> -128 without ReLU, 0 with ReLU
    set_pattern(3);
    start_run(1'b1);
    wait_done();
    check("sat_neg_slot2_relu", bus.VALUES_OUT[2*DW +: DW], 8'h00);
    check("sat_neg_slot2_norelu", bus_nr.VALUES_OUT[2*DW +: DW], 8'h80);

    // Run D: mixed signs, started at cycle 80 of run C
    @(negedge CLK);
    set_pattern(4);
    start_run(1'b1);
    wait_done();

    // Run E: ABORT during neuron 1 ISSUE
    @(negedge CLK);
    set_pattern(1);
    start_run(1'b0);
    exp_r  = sh_r;
    exp_nr = sh_nr;
    exp_r[0 +: DW]  = model_neuron(0, 1'b1);
    exp_nr[0 +: DW] = model_neuron(0, 1'b0);
    wait_rel(20);
    run_active = 1'b0;
    bus.ABORT  = 1'b1;
    @(negedge CLK);
    bus.ABORT  = 1'b0;
    check("abort_busy", bus.BUSY, 1'b0);
    check("abort_no_done", bus.DONE, 1'b0);
    check("abort_mac_en", bus.MAC_EN, 1'b0);
    check("abort_trace", 64'(trace_err), 64'd0);
    check("abort_values", bus.VALUES_OUT, exp_r);
    check("abort_values_nr", bus_nr.VALUES_OUT, exp_nr);
    sh_r  = exp_r;
    sh_nr = exp_nr;

    // Run F: restart at cycle 25 after the aborted start
    wait_rel(25);
    start_run(1'b1);
    wait_done();

    // Run G: reset mid-run, then a clean run
    @(negedge CLK);
    set_pattern(4);
    start_run(1'b0);
    wait_rel(40);
    run_active = 1'b0;
    RSTN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    check_all_zero("midrun_reset");
    sh_r  = '0;
    sh_nr = '0;
    @(negedge CLK);
    start_run(1'b1);
    wait_done();

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
